// File: rtl/free_list.sv
// free_list: circular free-PR list for rename, with speculative and
// architectural read pointers, 4-wide compacted alloc and 4-wide compacted free.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   flush_stage4                    restore head from a_head (+ this cycle's retires)
//   instK_alloc_en / alloc_fire     per-slot alloc requests, group advance
//   instK_alloc_PR / alloc_stall    combinational grants and stall
//   retireK_free_en / retireK_free_PR  PRs released at retire
//   free_count                      free entries, derived from registered pointers
module free_list (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_stage4,
  input  logic       inst0_alloc_en,
  input  logic       inst1_alloc_en,
  input  logic       inst2_alloc_en,
  input  logic       inst3_alloc_en,
  input  logic       alloc_fire,
  output logic [5:0] inst0_alloc_PR,
  output logic [5:0] inst1_alloc_PR,
  output logic [5:0] inst2_alloc_PR,
  output logic [5:0] inst3_alloc_PR,
  output logic       alloc_stall,
  input  logic       retire0_free_en,
  input  logic       retire1_free_en,
  input  logic       retire2_free_en,
  input  logic       retire3_free_en,
  input  logic [5:0] retire0_free_PR,
  input  logic [5:0] retire1_free_PR,
  input  logic [5:0] retire2_free_PR,
  input  logic [5:0] retire3_free_PR,
  output logic [5:0] free_count
);

  logic [5:0] r_mem [32];
  logic [5:0] r_head;
  logic [5:0] r_ahead;
  logic [5:0] r_tail;

  logic [3:0] w_aen;
  logic [3:0] w_fen;
  logic [5:0] w_fpr  [4];
  logic [2:0] w_aoff [5];
  logic [2:0] w_foff [5];
  logic [4:0] w_ridx [4];
  logic [4:0] w_widx [4];
  logic [2:0] w_n;
  logic [2:0] w_m;
  logic       w_alloc;
  logic [5:0] w_ahead_nxt;
  logic [5:0] w_head_nxt;
  logic [6:0] w_cnt_chk;

  assign w_aen = {inst3_alloc_en, inst2_alloc_en,
                  inst1_alloc_en, inst0_alloc_en};
  assign w_fen = {retire3_free_en, retire2_free_en,
                  retire1_free_en, retire0_free_en};
  assign w_fpr[0] = retire0_free_PR;
  assign w_fpr[1] = retire1_free_PR;
  assign w_fpr[2] = retire2_free_PR;
  assign w_fpr[3] = retire3_free_PR;

  // Running popcounts give each enabled slot its compacted offset.
  always_comb begin
    w_aoff[0] = 3'd0;
    w_foff[0] = 3'd0;
    for (int k = 0; k < 4; k++) begin
      w_aoff[k+1] = w_aoff[k] + {2'b00, w_aen[k]};
      w_foff[k+1] = w_foff[k] + {2'b00, w_fen[k]};
    end
    for (int k = 0; k < 4; k++) begin
      w_ridx[k] = r_head[4:0] + {2'b00, w_aoff[k]};
      w_widx[k] = r_tail[4:0] + {2'b00, w_foff[k]};
    end
  end

  assign w_n = w_aoff[4];
  assign w_m = w_foff[4];

  assign free_count     = r_tail - r_head;
  assign alloc_stall    = {3'b000, w_n} > free_count;
  assign w_alloc        = alloc_fire & ~alloc_stall & ~flush_stage4;
  assign inst0_alloc_PR = r_mem[w_ridx[0]];
  assign inst1_alloc_PR = r_mem[w_ridx[1]];
  assign inst2_alloc_PR = r_mem[w_ridx[2]];
  assign inst3_alloc_PR = r_mem[w_ridx[3]];

  assign w_ahead_nxt = r_ahead + {3'b000, w_m};

  always_comb begin
    w_head_nxt = r_head;
    if (flush_stage4)
      w_head_nxt = w_ahead_nxt;
    else if (w_alloc)
      w_head_nxt = r_head + {3'b000, w_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= 6'd0;
      r_ahead <= 6'd0;
      r_tail  <= 6'd32;
    end else begin
      r_head  <= w_head_nxt;
      r_ahead <= w_ahead_nxt;
      r_tail  <= r_tail + {3'b000, w_m};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        r_mem[i] <= 6'(32 + i);
    end else begin
      for (int k = 0; k < 4; k++)
        if (w_fen[k])
          r_mem[w_widx[k]] <= w_fpr[k];
    end
  end

  // Upstream must never free more PRs than the list can hold.
  assign w_cnt_chk = {1'b0, free_count} + {4'b0000, w_m}
                   - (w_alloc ? {4'b0000, w_n} : 7'd0);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    flush_stage4 || (w_cnt_chk <= 7'd32));

  a_ahead_lag: assert property (
    @(posedge clk) disable iff (!rst_n)
    (r_head - r_ahead) <= 6'd32);

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed vector table, hand-written stall/wrap sequence,
// and a randomized run against a queue-based reference model.
module tb_free_list;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [3:0]      aen;
  logic            fire;
  logic [3:0]      fen;
  logic [3:0][5:0] fpr;
  logic [3:0][5:0] pr;
  logic            stall;
  logic [5:0]      cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  free_list dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_stage4    (flush),
    .inst0_alloc_en  (aen[0]),
    .inst1_alloc_en  (aen[1]),
    .inst2_alloc_en  (aen[2]),
    .inst3_alloc_en  (aen[3]),
    .alloc_fire      (fire),
    .inst0_alloc_PR  (pr[0]),
    .inst1_alloc_PR  (pr[1]),
    .inst2_alloc_PR  (pr[2]),
    .inst3_alloc_PR  (pr[3]),
    .alloc_stall     (stall),
    .retire0_free_en (fen[0]),
    .retire1_free_en (fen[1]),
    .retire2_free_en (fen[2]),
    .retire3_free_en (fen[3]),
    .retire0_free_PR (fpr[0]),
    .retire1_free_PR (fpr[1]),
    .retire2_free_PR (fpr[2]),
    .retire3_free_PR (fpr[3]),
    .free_count      (cnt)
  );

  typedef struct {
    bit            rst;
    bit            flush;
    bit [3:0]      aen;
    bit            fire;
    bit [3:0]      fen;
    bit [5:0]      f0;
    bit [5:0]      f1;
    bit            stall;
    int            cnt;
    bit [3:0]      chk;
    int            p [4];
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(bit rst, bit fl, bit [3:0] a, bit fi,
                              bit [3:0] fe, bit [5:0] f0, bit [5:0] f1,
                              bit st, int c, bit [3:0] ck,
                              int p0, int p1, int p2, int p3);
    vec_t v;
    v.rst = rst; v.flush = fl; v.aen = a; v.fire = fi;
    v.fen = fe; v.f0 = f0; v.f1 = f1; v.stall = st; v.cnt = c;
    v.chk = ck; v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; aen = 4'd0; fire = 1'b0; fen = 4'd0; fpr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int afq [$];
  int used [$];
  int spec_n;

  initial begin
    rst_n = 1'b1;
    idle();

    // reset, full-width alloc
    vt[0]  = mk(1,0,4'h0,0,4'h0,0,0, 0,32,4'h0, 0,0,0,0);
    vt[1]  = mk(0,0,4'hF,1,4'h0,0,0, 0,32,4'hF, 32,33,34,35);
    vt[2]  = mk(0,0,4'h0,0,4'h0,0,0, 0,28,4'h0, 0,0,0,0);
    // mid-op reset, sparse enables {0,1,0,1}
    vt[3]  = mk(1,0,4'hA,1,4'h0,0,0, 0,32,4'hA, 0,32,0,33);
    vt[4]  = mk(0,0,4'h0,0,4'h0,0,0, 0,30,4'h0, 0,0,0,0);
    // 8 allocs, retire 2 freeing PR3/PR7, flush
    vt[5]  = mk(1,0,4'hF,1,4'h0,0,0, 0,32,4'hF, 32,33,34,35);
    vt[6]  = mk(0,0,4'hF,1,4'h0,0,0, 0,28,4'hF, 36,37,38,39);
    vt[7]  = mk(0,0,4'h0,0,4'h3,3,7, 0,24,4'h0, 0,0,0,0);
    vt[8]  = mk(0,1,4'h0,0,4'h0,0,0, 0,26,4'h0, 0,0,0,0);
    vt[9]  = mk(0,0,4'hF,1,4'h0,0,0, 0,32,4'hF, 34,35,36,37);
    vt[10] = mk(0,0,4'h0,0,4'h0,0,0, 0,28,4'h0, 0,0,0,0);
    // flush + retire 1 + alloc_fire n=4 in one cycle
    vt[11] = mk(1,0,4'hF,1,4'h0,0,0, 0,32,4'hF, 32,33,34,35);
    vt[12] = mk(0,1,4'hF,1,4'h1,9,0, 0,28,4'hF, 36,37,38,39);
    vt[13] = mk(0,0,4'h1,0,4'h0,0,0, 0,32,4'h1, 33,0,0,0);
    vt[14] = mk(0,0,4'h1,1,4'h0,0,0, 0,32,4'h1, 33,0,0,0);
    vt[15] = mk(0,0,4'h0,0,4'h0,0,0, 0,31,4'h0, 0,0,0,0);

    for (int i = 0; i < 16; i++) begin
      if (vt[i].rst) do_reset();
      @(negedge clk);
      flush  = vt[i].flush;
      aen    = vt[i].aen;
      fire   = vt[i].fire;
      fen    = vt[i].fen;
      fpr    = '0;
      fpr[0] = vt[i].f0;
      fpr[1] = vt[i].f1;
      #1;
      chk($sformatf("v%0d_stall", i), int'(stall), int'(vt[i].stall));
      chk($sformatf("v%0d_count", i), int'(cnt), vt[i].cnt);
      for (int k = 0; k < 4; k++)
        if (vt[i].chk[k])
          chk($sformatf("v%0d_pr%0d", i, k), int'(pr[k]), vt[i].p[k]);
    end

    // drain to empty across the wrap, stall, then refill with one free
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      idle(); aen = 4'hF; fire = 1'b1;
      #1;
      chk($sformatf("drain%0d_count", c), int'(cnt), 32 - 4*c);
      chk($sformatf("drain%0d_stall", c), int'(stall), 0);
      for (int k = 0; k < 4; k++)
        chk($sformatf("drain%0d_pr%0d", c, k), int'(pr[k]), 32 + 4*c + k);
    end
    @(negedge clk);
    idle(); aen = 4'h1; fire = 1'b1;
    #1;
    chk("empty_count", int'(cnt), 0);
    chk("empty_stall", int'(stall), 1);
    @(negedge clk);
    idle(); fen = 4'h1; fpr[0] = 6'd5;
    #1;
    chk("stall_hold_count", int'(cnt), 0);
    @(negedge clk);
    idle(); aen = 4'h1; fire = 1'b1;
    #1;
    chk("refill_stall", int'(stall), 0);
    chk("refill_pr0", int'(pr[0]), 5);
    chk("refill_count", int'(cnt), 1);
    @(negedge clk);
    idle();
    #1;
    chk("refill_after", int'(cnt), 0);

    // randomized run against a queue model
    do_reset();
    afq.delete(); used.delete();
    for (int i = 0; i < 32; i++) begin
      afq.push_back(32 + i);
      used.push_back(i);
    end
    spec_n = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      bit [3:0] a, f;
      bit fi, fl, est;
      int n, m, c, off, idx, found;
      @(negedge clk);
      a  = 4'($urandom_range(0, 15));
      fi = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 9) == 0);
      f  = 4'($urandom_range(0, 15));
      while ($countones(f) > spec_n) f = f & (f - 4'd1);
      fpr = '0;
      for (int k = 0; k < 4; k++)
        if (f[k]) begin
          idx = $urandom_range(0, used.size() - 1);
          fpr[k] = 6'(used[idx]);
          used.delete(idx);
        end
      flush = fl; aen = a; fire = fi; fen = f;
      #1;
      n   = $countones(a);
      m   = $countones(f);
      c   = afq.size() - spec_n;
      est = (n > c);
      chk($sformatf("rnd%0d_count", cyc), int'(cnt), c);
      chk($sformatf("rnd%0d_stall", cyc), int'(stall), int'(est));
      if (!est) begin
        off = 0;
        for (int k = 0; k < 4; k++)
          if (a[k]) begin
            chk($sformatf("rnd%0d_pr%0d", cyc, k), int'(pr[k]),
                afq[spec_n + off]);
            found = 0;
            foreach (used[j]) if (used[j] == int'(pr[k])) found = 1;
            chk($sformatf("rnd%0d_dup%0d", cyc, k), found, 0);
            off++;
          end
      end
      for (int j = 0; j < m; j++) used.push_back(afq.pop_front());
      spec_n -= m;
      for (int k = 0; k < 4; k++)
        if (f[k]) afq.push_back(int'(fpr[k]));
      if (fl) spec_n = 0;
      else if (fi && !est) spec_n += n;
    end

    @(negedge clk);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 clk  input  1  — single clock; all state updates on posedge clk.
REQ-002 rst_n  input  1  — reset, asynchronous, active-low.
REQ-003 flush_stage4  input  1  — pipeline flush; recover the speculative allocation pointer.
REQ-004 inst0_alloc_en..inst3_alloc_en  input  1 each  — rename slot k needs a new destination PR.
REQ-005 alloc_fire  input  1  — rename group advances this cycle; commit the allocations.
REQ-006 inst0_alloc_PR..inst3_alloc_PR  output  6 each  — PR granted to slot k (combinational).
REQ-007 alloc_stall  output  1  — free entries insufficient for the enabled slots (combinational).
REQ-008 retire0_free_en..retire3_free_en  input  1 each  — retire slot k releases an old PR; same slot also commits one allocation.
REQ-009 retire0_free_PR..retire3_free_PR  input  6 each  — PR released by retire slot k.
REQ-010 free_count  output  6  — registered number of free entries, 0..32.

Function
REQ-011 Storage: circular buffer of 32 entries x 6 bits; pointers head (speculative read), a_head (architectural read), tail (write); each pointer is 6 bits (5-bit index + wrap bit); all arithmetic is modulo 64.
REQ-012 free_count = tail - head (6-bit); full = 32 with index bits equal and wrap bits different; empty = 0 with pointers equal.
REQ-013 Requested count n = popcount(inst0..3_alloc_en), 0..4.
REQ-014 Compaction: instk_alloc_PR = entry[(head + popcount of enables of slots 0..k-1) mod 32]; the value is unspecified when instk_alloc_en=0.
REQ-015 alloc_stall = (n > free_count); stall uses only the registered count, and PRs freed in the same cycle are not visible until the next cycle.
REQ-016 Allocation happens only when alloc_fire=1, alloc_stall=0 and flush_stage4=0; head then advances by n on the next edge; otherwise head holds.
REQ-017 alloc_fire=1 with alloc_stall=1 is ignored; head does not move and no partial allocation occurs.
REQ-018 Frees: m = popcount(retire0..3_free_en); enabled PRs are written compacted in slot order to entry[tail], entry[tail+1], ...; tail advances by m.
REQ-019 a_head advances by m every cycle, including flush cycles.
REQ-020 Flush: on flush_stage4=1, head <= a_head + m (post-retire value); allocation is suppressed that cycle; frees in the same cycle still write and tail still advances.
REQ-021 tail and the entry contents are never rolled back by flush.
REQ-022 Latency: granted PRs are valid in the same cycle as the request; a freed PR becomes allocatable 1 cycle after its free.
REQ-023 Simultaneous alloc and free in one cycle: both take effect; next free_count = free_count - n + m.
REQ-024 Overflow guard: the block does not check for tail overtaking head; upstream guarantees at most 32 PRs are free. Simulation asserts free_count + m - n <= 32.
REQ-025 a_head never passes head outside a flush; simulation asserts (head - a_head) <= 32.

Reset
REQ-026 When rst_n=0, asynchronously set entry[i] = 32+i for i=0..31, head=0, a_head=0, tail=6'b100000 (32).
REQ-027 After reset: free_count=32, alloc_stall=0 for any n<=4, inst0_alloc_PR=32 when inst0_alloc_en=1.
REQ-028 Reset asserted mid-operation discards all pending allocations and frees and returns every pointer to its REQ-026 value.

Verification
REQ-029 Reset, then all four enables set with alloc_fire -> PRs 32,33,34,35; next cycle free_count=28.
REQ-030 Enables {0,1,0,1} with alloc_fire from reset -> inst1_alloc_PR=32, inst3_alloc_PR=33; free_count=30.
REQ-031 Allocate 4/cycle for 8 cycles -> free_count=0; cycle 9 with n=1 -> alloc_stall=1, head unchanged; free PR 5 -> next cycle n=1 grants PR 5, no stall.
REQ-032 Allocate 8 PRs (32..39), retire 2 with frees of PRs 3 and 7, then flush -> head=a_head=2, next grants 34,35,...; free_count=32-2+2=32.
REQ-033 Flush in the same cycle as retire of 1 with alloc_fire and n=4 -> no allocation; head=a_head+1; tail+1.
REQ-034 Run 200+ cycles of random alloc, free and flush against a reference queue model -> granted PRs match, no duplicate live PR, no assertion fires.
